// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage of the 32-bit pipelined MIPS core.
//   NOP_INSTR        : encoding loaded into IF/ID as a bubble (sll $0,$0,0)
//   RESET_PC_DEFAULT : default PC after reset
//   OPCODE_/FUNCT_*  : bit positions of the fields decoded by the control unit
//   JUMP_INDEX_MSB   : top bit of the J-type 26-bit instruction index
//   fetch_state_e    : fetch FSM states (memory ready / waiting on memory)
package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB     = 31;
  localparam int unsigned OPCODE_LSB     = 26;
  localparam int unsigned FUNCT_MSB      = 5;
  localparam int unsigned FUNCT_LSB      = 0;
  localparam int unsigned JUMP_INDEX_MSB = 25;

  typedef enum logic {
    StRun  = 1'b0,
    StWait = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Harvard instruction-memory port.
//   ImemAddr  : fetch address (driven by the fetch unit, master)
//   ImemRdata : instruction word for ImemAddr (driven by memory, slave)
//   ImemReady : ImemRdata is valid this cycle (driven by memory, slave)
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]  ImemAddr;
  logic [INSTR_WIDTH-1:0] ImemRdata;
  logic                   ImemReady;

  modport master (
    output ImemAddr,
    input  ImemRdata,
    input  ImemReady
  );

  modport slave (
    input  ImemAddr,
    output ImemRdata,
    output ImemReady
  );

endinterface

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
//   clk_i, rst_ni : clock, synchronous active-low reset (loads a bubble)
//   stall_i       : hold current contents
//   flush_i       : load a bubble; wins over stall_i
//   load_i        : fetched word is valid; when low (and not stalled) load a bubble
//   instr_i       : fetched instruction word
//   pc_plus4_i    : address of the fetched word plus 4
//   instr_o, pc_plus4_o, valid_o : registered outputs
module if_id_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   load_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [ADDR_WIDTH-1:0]  pc_plus4_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_o,
  output logic                   valid_o
);

  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pc_plus4_q, pc_plus4_d;
  logic                   valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush_i || (!stall_i && !load_i)) begin
      instr_d    = INSTR_WIDTH'(NOP_INSTR);
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (!stall_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      instr_q    <= INSTR_WIDTH'(NOP_INSTR);
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage plus IF/ID register of the pipelined MIPS core.
//   CLK, RST          : clock, synchronous active-low reset
//   StallF, StallD    : hazard-unit holds for the PC and the IF/ID register
//   FlushD            : load a bubble into IF/ID
//   PCSrcD, PCBranchD : taken branch and its target, resolved in Decode
//   JumpD             : instruction in Decode is J (target built from InstrD)
//   imem              : instruction-memory port (ImemAddr/ImemRdata/ImemReady)
//   PCF               : current fetch PC
//   InstrD, PCPlus4D, ValidD, OpcodeD, FunctD : decode-stage view of IF/ID
// Optional macro FETCH_PERF_CNT_EN adds FetchCnt/BubbleCnt performance counters.
// ADDR_WIDTH is expected to be 32: the jump target concatenation is 32 bits wide.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     FlushD,
  input  logic                     PCSrcD,
  input  logic [ADDR_WIDTH-1:0]    PCBranchD,
  input  logic                     JumpD,
  instruction_fetch_unit_if.master imem,
  output logic [ADDR_WIDTH-1:0]    PCF,
  output logic [INSTR_WIDTH-1:0]   InstrD,
  output logic [ADDR_WIDTH-1:0]    PCPlus4D,
  output logic [5:0]               OpcodeD,
  output logic [5:0]               FunctD,
  output logic                     ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              FetchCnt,
  output logic [31:0]              BubbleCnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_plus4, jump_target, redirect_target;
  logic redirect, fetch_ok, flush_if_id;

  assign pc_plus4        = pc_q + ADDR_WIDTH'(4);  // wraps modulo 2^ADDR_WIDTH
  assign jump_target     = {PCPlus4D[ADDR_WIDTH-1 -: 4], InstrD[JUMP_INDEX_MSB:0], 2'b00};
  assign redirect        = PCSrcD | JumpD;
  assign redirect_target = PCSrcD ? PCBranchD : jump_target;
  assign flush_if_id     = FlushD | redirect;

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; StallF freezes it
  always_comb begin
    state_d = state_q;
    if (!StallF) begin
      unique case (state_q)
        StRun:   if (!imem.ImemReady) state_d = StWait;
        StWait:  if (imem.ImemReady)  state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  // FSM: outputs. In either state a word is consumed only on a ready cycle;
  // WAIT records that the fetch at PCF is still outstanding.
  always_comb begin
    fetch_ok = 1'b0;
    unique case (state_q)
      StRun:   fetch_ok = imem.ImemReady;
      StWait:  fetch_ok = imem.ImemReady;
      default: fetch_ok = 1'b0;
    endcase
  end

  // Next PC: a redirect is taken even while memory is not ready.
  always_comb begin
    pc_d = pc_q;
    if (StallF) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d = redirect_target;
    end else if (fetch_ok) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  if_id_reg #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .stall_i    (StallD),
    .flush_i    (flush_if_id),
    .load_i     (fetch_ok),
    .instr_i    (imem.ImemRdata),
    .pc_plus4_i (pc_plus4),
    .instr_o    (InstrD),
    .pc_plus4_o (PCPlus4D),
    .valid_o    (ValidD)
  );

  assign PCF           = pc_q;
  assign imem.ImemAddr = pc_q;
  assign OpcodeD       = InstrD[OPCODE_MSB:OPCODE_LSB];
  assign FunctD        = InstrD[FUNCT_MSB:FUNCT_LSB];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;
  logic        load_valid, load_bubble;

  // Mirror the IF/ID priority: flush wins, stall holds (counts nothing).
  assign load_valid  = !flush_if_id && !StallD && fetch_ok;
  assign load_bubble = flush_if_id || (!StallD && !fetch_ok);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (load_valid)  fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign FetchCnt  = fetch_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, StallF, StallD, FlushD, PCSrcD, JumpD;
  logic [31:0] PCBranchD, PCF, InstrD, PCPlus4D;
  logic [5:0]  OpcodeD, FunctD;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCnt, BubbleCnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [64];

  instruction_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) imem_bus ();

  assign imem_bus.ImemRdata = mem[imem_bus.ImemAddr[7:2]];

  instruction_fetch_unit #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .JumpD     (JumpD),
    .imem      (imem_bus),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .OpcodeD   (OpcodeD),
    .FunctD    (FunctD),
    .ValidD    (ValidD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCnt  (FetchCnt),
    .BubbleCnt (BubbleCnt)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    StallF = 0; StallD = 0; FlushD = 0; PCSrcD = 0; JumpD = 0; PCBranchD = 32'h0;
    imem_bus.ImemReady = 1'b1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    RST = 0;
    tick();
    RST = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 0;
    tick();
    tick();
    checks++; if (PCF !== 32'h0) begin failures++; $display("FAIL rst_pcf got=%h exp=%h", PCF, 32'h0); end
    checks++; if (imem_bus.ImemAddr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=%h", imem_bus.ImemAddr, 32'h0); end
    checks++; if (InstrD !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=%h", InstrD, 32'h0); end
    checks++; if (PCPlus4D !== 32'h0) begin failures++; $display("FAIL rst_pcp4 got=%h exp=%h", PCPlus4D, 32'h0); end
    checks++; if (ValidD !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ValidD); end
    checks++; if (OpcodeD !== 6'h0 || FunctD !== 6'h0) begin failures++; $display("FAIL rst_fields got=%h/%h exp=0/0", OpcodeD, FunctD); end
    checks++; if (dut.state_q !== StRun) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dut.state_q, StRun); end
    RST = 1;
  endtask

  task automatic test_sequential();
    checks++; if (PCF !== 32'h0) begin failures++; $display("FAIL seq_pc0 got=%h exp=%h", PCF, 32'h0); end
    tick();
    checks++; if (PCF !== 32'h4) begin failures++; $display("FAIL seq_pc1 got=%h exp=%h", PCF, 32'h4); end
    checks++; if (InstrD !== 32'h2008_0001 || ValidD !== 1'b1) begin failures++; $display("FAIL seq_instr1 got=%h/%b exp=%h/1", InstrD, ValidD, 32'h2008_0001); end
    checks++; if (OpcodeD !== 6'h08 || PCPlus4D !== 32'h4) begin failures++; $display("FAIL seq_op1 got=%h/%h exp=08/00000004", OpcodeD, PCPlus4D); end
    tick();
    checks++; if (PCF !== 32'h8) begin failures++; $display("FAIL seq_pc2 got=%h exp=%h", PCF, 32'h8); end
    checks++; if (InstrD !== 32'h2009_0002 || OpcodeD !== 6'h08) begin failures++; $display("FAIL seq_instr2 got=%h/%h exp=%h/08", InstrD, OpcodeD, 32'h2009_0002); end
    tick();
    checks++; if (PCF !== 32'hC) begin failures++; $display("FAIL seq_pc3 got=%h exp=%h", PCF, 32'hC); end
    checks++; if (InstrD !== 32'h0109_5020 || PCPlus4D !== 32'hC) begin failures++; $display("FAIL seq_instr3 got=%h/%h exp=%h/0000000c", InstrD, PCPlus4D, 32'h0109_5020); end
    checks++; if (OpcodeD !== 6'h00 || FunctD !== 6'h20) begin failures++; $display("FAIL seq_fields3 got=%h/%h exp=00/20", OpcodeD, FunctD); end
  endtask

  task automatic test_branch();
    PCSrcD = 1; PCBranchD = 32'h40;
    tick();
    PCSrcD = 0;
    checks++; if (PCF !== 32'h40) begin failures++; $display("FAIL br_pcf got=%h exp=%h", PCF, 32'h40); end
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus4D !== 32'h0) begin failures++; $display("FAIL br_bubble got=%b/%h/%h exp=0/0/0", ValidD, InstrD, PCPlus4D); end
    tick();
    checks++; if (PCF !== 32'h44) begin failures++; $display("FAIL br_pcf2 got=%h exp=%h", PCF, 32'h44); end
    checks++; if (InstrD !== 32'h2400_0010 || ValidD !== 1'b1 || PCPlus4D !== 32'h44) begin failures++; $display("FAIL br_target got=%h/%b/%h exp=24000010/1/00000044", InstrD, ValidD, PCPlus4D); end
  endtask

  task automatic test_jump();
    mem[1] = 32'h0800_0010;
    apply_reset();
    tick();
    tick();
    checks++; if (InstrD !== 32'h0800_0010 || PCPlus4D !== 32'h8) begin failures++; $display("FAIL j_setup got=%h/%h exp=08000010/00000008", InstrD, PCPlus4D); end
    JumpD = 1;
    tick();
    JumpD = 0;
    checks++; if (PCF !== 32'h40) begin failures++; $display("FAIL j_pcf got=%h exp=%h", PCF, 32'h40); end
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin failures++; $display("FAIL j_bubble got=%b/%h exp=0/0", ValidD, InstrD); end
    tick();
    checks++; if (PCF !== 32'h44 || InstrD !== 32'h2400_0010) begin failures++; $display("FAIL j_after got=%h/%h exp=00000044/24000010", PCF, InstrD); end
    // Both redirects: branch target 0x100 must beat jump target 0x40
    PCSrcD = 1; PCBranchD = 32'h100; JumpD = 1;
    tick();
    clear_inputs();
    checks++; if (PCF !== 32'h100) begin failures++; $display("FAIL j_prio got=%h exp=%h", PCF, 32'h100); end
    mem[1] = 32'h2009_0002;
  endtask

  task automatic test_stall();
    apply_reset();
    repeat (4) tick();
    checks++; if (PCF !== 32'h10 || InstrD !== 32'h2400_0003) begin failures++; $display("FAIL st_setup got=%h/%h exp=00000010/24000003", PCF, InstrD); end
    StallF = 1; StallD = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (PCF !== 32'h10 || InstrD !== 32'h2400_0003 || ValidD !== 1'b1) begin
        failures++;
        $display("FAIL st_hold%0d got=%h/%h/%b exp=00000010/24000003/1", i, PCF, InstrD, ValidD);
      end
    end
    FlushD = 1;
    tick();
    checks++; if (InstrD !== 32'h0 || ValidD !== 1'b0 || PCF !== 32'h10) begin failures++; $display("FAIL st_flush got=%h/%b/%h exp=0/0/00000010", InstrD, ValidD, PCF); end
    clear_inputs();
    tick();
    checks++; if (PCF !== 32'h14 || InstrD !== 32'h2400_0004 || PCPlus4D !== 32'h14) begin failures++; $display("FAIL st_resume got=%h/%h/%h exp=00000014/24000004/00000014", PCF, InstrD, PCPlus4D); end
  endtask

  task automatic test_wait();
    repeat (3) tick();
    checks++; if (PCF !== 32'h20) begin failures++; $display("FAIL w_setup got=%h exp=%h", PCF, 32'h20); end
    imem_bus.ImemReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (PCF !== 32'h20 || dut.state_q !== StWait || ValidD !== 1'b0 || InstrD !== 32'h0) begin
        failures++;
        $display("FAIL w_hold%0d got=%h/%0d/%b/%h exp=00000020/1/0/0", i, PCF, dut.state_q, ValidD, InstrD);
      end
    end
    PCSrcD = 1; PCBranchD = 32'h80;
    tick();
    PCSrcD = 0;
    checks++; if (PCF !== 32'h80 || ValidD !== 1'b0) begin failures++; $display("FAIL w_redirect got=%h/%b exp=00000080/0", PCF, ValidD); end
    imem_bus.ImemReady = 1'b1;
    tick();
    checks++; if (PCF !== 32'h84 || InstrD !== 32'h2400_0020 || ValidD !== 1'b1) begin failures++; $display("FAIL w_resume got=%h/%h/%b exp=00000084/24000020/1", PCF, InstrD, ValidD); end
    checks++; if (dut.state_q !== StRun) begin failures++; $display("FAIL w_state got=%0d exp=%0d", dut.state_q, StRun); end
  endtask

  task automatic test_wrap();
    PCSrcD = 1; PCBranchD = 32'hFFFF_FFFC;
    tick();
    PCSrcD = 0;
    checks++; if (PCF !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_top got=%h exp=%h", PCF, 32'hFFFF_FFFC); end
    tick();
    checks++; if (PCF !== 32'h0 || PCPlus4D !== 32'h0) begin failures++; $display("FAIL wr_wrap got=%h/%h exp=0/0", PCF, PCPlus4D); end
    checks++; if (InstrD !== 32'h2400_003F || ValidD !== 1'b1) begin failures++; $display("FAIL wr_instr got=%h/%b exp=2400003f/1", InstrD, ValidD); end
  endtask

  task automatic test_reset_mid();
    tick();
    imem_bus.ImemReady = 1'b0;
    tick();
    checks++; if (PCF !== 32'h4 || dut.state_q !== StWait) begin failures++; $display("FAIL rm_setup got=%h/%0d exp=00000004/1", PCF, dut.state_q); end
    RST = 0; StallF = 1; StallD = 1; PCSrcD = 1; PCBranchD = 32'h200;
    tick();
    checks++; if (PCF !== 32'h0 || ValidD !== 1'b0 || InstrD !== 32'h0) begin failures++; $display("FAIL rm_regs got=%h/%b/%h exp=0/0/0", PCF, ValidD, InstrD); end
    checks++; if (dut.state_q !== StRun) begin failures++; $display("FAIL rm_state got=%0d exp=%0d", dut.state_q, StRun); end
    clear_inputs();
    RST = 1;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic [9:0] pattern;
    pattern = 10'b1101101101;
    apply_reset();
    checks++; if (FetchCnt !== 32'd0 || BubbleCnt !== 32'd0) begin failures++; $display("FAIL pc_rst got=%0d/%0d exp=0/0", FetchCnt, BubbleCnt); end
    for (int i = 9; i >= 0; i--) begin
      imem_bus.ImemReady = pattern[i];
      tick();
    end
    imem_bus.ImemReady = 1'b1;
    checks++; if (FetchCnt !== 32'd7) begin failures++; $display("FAIL pc_fetch got=%0d exp=7", FetchCnt); end
    checks++; if (BubbleCnt !== 32'd3) begin failures++; $display("FAIL pc_bubble got=%0d exp=3", BubbleCnt); end
    RST = 0;
    tick();
    RST = 1;
    checks++; if (FetchCnt !== 32'd0 || BubbleCnt !== 32'd0) begin failures++; $display("FAIL pc_midrst got=%0d/%0d exp=0/0", FetchCnt, BubbleCnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 | 32'(i);
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_wait();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
